bpm_detector: RTL and testbench

Tap-tempo receiver. It measures the clk-cycle period between rising edges on an external beat or tap input and converts that period to beats per minute using a sequential divider. The result is clamped to 40..200 BPM and presented as an 8-bit BPM value with valid/update flags. It sits on the input side of the metronome path, so a measured tempo can be fed back into the beat generator.

---
 rtl/bpm_detector.sv | 138 +++++++++++++
 tb/tb_bpm_detector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpm_detector.sv
// Tap-tempo receiver: measures clk cycles between beat_in rising edges and converts to BPM.
// Result appears NW+1 cycles after edge detection; edges arriving mid-divide restart timing only.
module bpm_detector #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int MIN_BPM    = 40,
  parameter int MAX_BPM    = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beat_in,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       bpm_update,
  output logic       timeout,
  output logic       busy
);

  localparam longint N          = longint'(CLOCK_FREQ) * 60;
  localparam int     NW         = $clog2(N + 1);
  localparam longint MAX_PERIOD = N / longint'(MIN_BPM);
  localparam int     PW         = $clog2(MAX_PERIOD + 1);
  localparam int     BW         = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [NW-1:0] N_VEC   = NW'(N);
  localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PERIOD);
  localparam logic [NW-1:0] Q_MIN   = NW'(MIN_BPM);
  localparam logic [NW-1:0] Q_MAX   = NW'(MAX_BPM);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, OUTPUT} state_t;
  state_t state, state_next;

  logic          sync1, sync2, hist;
  logic          beat_edge;
  logic [PW-1:0] cnt;
  logic          cnt_sat;
  logic [PW:0]   period;
  logic [PW-1:0] rem;
  logic [PW:0]   trial;
  logic          q_bit;
  logic [NW-1:0] quot;
  logic [BW-1:0] bit_idx;
  logic [7:0]    bpm_clamped;

  assign beat_edge = sync2 & ~hist;
  assign cnt_sat   = (cnt == MAX_CNT);
  assign busy      = (state == DIVIDE) || (state == OUTPUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= beat_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Restoring divide step: remainder stays below the divisor, so PW bits suffice.
  always_comb begin
    trial       = {rem, N_VEC[bit_idx]};
    q_bit       = (trial >= period);
    bpm_clamped = quot[7:0];
    if (quot > Q_MAX)
      bpm_clamped = 8'(MAX_BPM);
    else if (quot < Q_MIN)
      bpm_clamped = 8'(MIN_BPM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (beat_edge) state_next = MEASURE;
      MEASURE: begin
        if (beat_edge)    state_next = DIVIDE;
        else if (cnt_sat) state_next = IDLE;
      end
      DIVIDE:  if (bit_idx == '0) state_next = OUTPUT;
      OUTPUT:  state_next = MEASURE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      period     <= '0;
      rem        <= '0;
      quot       <= '0;
      bit_idx    <= '0;
      bpm        <= '0;
      bpm_valid  <= 1'b0;
      bpm_update <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      bpm_update <= 1'b0;
      timeout    <= 1'b0;

      // Cleared on every edge so the next interval starts immediately, even mid-divide.
      if (beat_edge || state == IDLE)
        cnt <= '0;
      else if (!cnt_sat)
        cnt <= cnt + PW'(1);

      case (state)
        MEASURE: begin
          if (beat_edge) begin
            period  <= {1'b0, cnt} + (PW+1)'(1);
            rem     <= '0;
            quot    <= '0;
            bit_idx <= BW'(NW - 1);
          end else if (cnt_sat) begin
            timeout   <= 1'b1;
            bpm_valid <= 1'b0;
          end
        end
        DIVIDE: begin
          rem     <= PW'(q_bit ? trial - period : trial);
          quot    <= {quot[NW-2:0], q_bit};
          bit_idx <= bit_idx - BW'(1);
        end
        OUTPUT: begin
          bpm        <= bpm_clamped;
          bpm_valid  <= 1'b1;
          bpm_update <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_detector.sv
// Scoreboard bench for bpm_detector at CLOCK_FREQ=1000 (N=60000, NW=16, MAX_PERIOD=1500).
module tb_bpm_detector;

  localparam int NW         = 16;
  localparam int MAX_PERIOD = 1500;
  // Input driven at a negedge is detected 3 posedges later; update follows NW+1 edges after that.
  localparam int LAT_UPD    = 3 + NW + 1;
  localparam int LAT_TO     = 3 + MAX_PERIOD + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beat_in = 1'b0;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       bpm_update;
  logic       timeout;
  logic       busy;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int last_drive = 0;

  typedef struct {
    int cyc;
    int bpm;
  } exp_t;

  exp_t upd_q[$];
  int   to_q[$];

  bpm_detector #(
    .CLOCK_FREQ(1000),
    .MIN_BPM(40),
    .MAX_BPM(200)
  ) dut (
    .clk(clk),
    .reset(reset),
    .beat_in(beat_in),
    .bpm(bpm),
    .bpm_valid(bpm_valid),
    .bpm_update(bpm_update),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (!reset) begin
      if (bpm_update || timeout) begin
        compared++;
        if (bpm_update && timeout) begin
          mismatched++;
          $display("FAIL update_timeout_overlap: both high at cycle %0d, required at most one", cyc);
        end
      end
      if (bpm_update) begin
        compared++;
        if (upd_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_update: cycle %0d bpm %0d, required no update", cyc, bpm);
        end else begin
          e = upd_q.pop_front();
          if (cyc !== e.cyc || bpm !== 8'(e.bpm) || bpm_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL update: cycle %0d bpm %0d valid %b, required cycle %0d bpm %0d valid 1",
                     cyc, bpm, bpm_valid, e.cyc, e.bpm);
          end
        end
      end
      if (upd_q.size() > 0 && upd_q[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missing_update: none at cycle %0d, required bpm %0d", upd_q[0].cyc, upd_q[0].bpm);
        void'(upd_q.pop_front());
      end
      if (timeout) begin
        compared++;
        if (to_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_timeout: cycle %0d, required no timeout", cyc);
        end else begin
          t = to_q.pop_front();
          if (cyc !== t || bpm_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout: cycle %0d valid %b, required cycle %0d valid 0", cyc, bpm_valid, t);
          end
        end
      end
      if (to_q.size() > 0 && to_q[0] < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missing_timeout: none at cycle %0d", to_q[0]);
        void'(to_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    beat_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise beat_in now (at a negedge) for hi cycles; next rise is gap cycles later.
  task automatic beat(input int gap, input int hi, input int exp_bpm);
    exp_t e;
    beat_in    = 1'b1;
    last_drive = cyc;
    if (exp_bpm >= 0) begin
      e.cyc = cyc + LAT_UPD;
      e.bpm = exp_bpm;
      upd_q.push_back(e);
    end
    repeat (hi) @(negedge clk);
    beat_in = 1'b0;
    repeat (gap - hi) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared += 5;
    if (bpm !== 8'd0) begin mismatched++; $display("FAIL reset_bpm: got %0d required 0", bpm); end
    if (bpm_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b required 0", bpm_valid); end
    if (bpm_update !== 1'b0) begin mismatched++; $display("FAIL reset_update: got %b required 0", bpm_update); end
    if (timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b required 0", timeout); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_steady();
    do_reset();
    beat(500, 4, -1);
    for (int i = 0; i < 4; i++) beat(500, 4, 120);
    compared++;
    if (upd_q.size() != 0 || bpm !== 8'd120 || bpm_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL steady_end: pending %0d bpm %0d valid %b, required 0 120 1", upd_q.size(), bpm, bpm_valid);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    beat(1400, 4, -1);
    beat(300, 4, 42);
    beat(250, 4, 200);
    beat(1501, 4, 200);
    beat(1500, 4, 40);   // edge coincides with saturation: clamped, no timeout
    beat(100, 4, 40);
    compared++;
    if (upd_q.size() != 0 || to_q.size() != 0 || bpm !== 8'd40) begin
      mismatched++;
      $display("FAIL clamp_end: pending %0d/%0d bpm %0d, required 0/0 40", upd_q.size(), to_q.size(), bpm);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    beat(500, 4, -1);
    beat(500, 4, 120);
    to_q.push_back(last_drive + LAT_TO);
    repeat (1010) @(negedge clk);
    compared++;
    if (to_q.size() != 0 || bpm_valid !== 1'b0 || bpm !== 8'd120) begin
      mismatched++;
      $display("FAIL timeout_state: pending %0d valid %b bpm %0d, required 0 0 120", to_q.size(), bpm_valid, bpm);
    end
    beat(600, 4, -1);
    compared++;
    if (bpm_valid !== 1'b0 || bpm !== 8'd120) begin
      mismatched++;
      $display("FAIL rearm: valid %b bpm %0d, required 0 120", bpm_valid, bpm);
    end
    beat(100, 4, 100);
    compared++;
    if (upd_q.size() != 0 || bpm !== 8'd100 || bpm_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL relock: pending %0d bpm %0d valid %b, required 0 100 1", upd_q.size(), bpm, bpm_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    beat(500, 4, -1);
    beat(10, 4, 120);
    beat(500, 4, -1);    // lands mid-divide: discarded, restarts the interval
    beat(500, 4, 120);
    beat(50, 4, 120);
    compared++;
    if (upd_q.size() != 0 || bpm !== 8'd120 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_end: pending %0d bpm %0d busy %b, required 0 120 0", upd_q.size(), bpm, busy);
    end
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    beat(500, 4, -1);
    beat(500, 4, 120);
    beat_in = 1'b1;
    repeat (8) @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_divide_busy: got %b required 1", busy); end
    reset   = 1'b1;
    beat_in = 1'b0;
    @(negedge clk);
    compared += 4;
    if (bpm !== 8'd0) begin mismatched++; $display("FAIL abort_bpm: got %0d required 0", bpm); end
    if (bpm_valid !== 1'b0) begin mismatched++; $display("FAIL abort_valid: got %b required 0", bpm_valid); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (bpm_update !== 1'b0) begin mismatched++; $display("FAIL abort_update: got %b required 0", bpm_update); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    compared++;
    if (bpm_valid !== 1'b0 || bpm !== 8'd0) begin
      mismatched++;
      $display("FAIL post_abort: valid %b bpm %0d, required 0 0", bpm_valid, bpm);
    end
    beat(500, 4, -1);
    compared++;
    if (bpm_valid !== 1'b0) begin mismatched++; $display("FAIL abort_arm: valid %b required 0", bpm_valid); end
    beat(100, 4, 120);
    compared++;
    if (upd_q.size() != 0 || bpm !== 8'd120 || bpm_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_relock: pending %0d bpm %0d valid %b, required 0 120 1", upd_q.size(), bpm, bpm_valid);
    end
  endtask

  task automatic test_long_high();
    do_reset();
    beat(1200, 1000, -1);
    beat(100, 4, 50);
    compared++;
    if (upd_q.size() != 0 || bpm !== 8'd50) begin
      mismatched++;
      $display("FAIL long_high: pending %0d bpm %0d, required 0 50", upd_q.size(), bpm);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_steady();
    test_clamp();
    test_timeout();
    test_back_to_back();
    test_reset_mid_divide();
    test_long_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
